histogram_engine: RTL and testbench

HISTOGRAM_ENGINE -- requirements
Module: histogram_engine

---
 rtl/histogram_engine.sv | 238 +++++++++++++++++++++++
 tb/tb_histogram_engine.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_engine.sv
// histogram_engine: pixel-intensity histogram with a read-modify-write bin
// pipeline, multi-frame accumulation and an AXI4-Lite read-only window onto
// the bins and the status/total registers.
module histogram_engine #(
    parameter int PIX_W    = 8,
    parameter int BIN_BITS = 8,
    parameter int CNT_W    = 24,
    parameter int FRAMES   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PIX_W-1:0]  pix_i,
    input  logic              dv_i,
    input  logic              vs_i,
    input  logic              cpu_trigger,
    output logic              cpu_signal_done,
    input  logic [31:0]       s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready
);

    localparam int NBINS = 1 << BIN_BITS;
    localparam int FRM_W = $clog2(FRAMES + 1);
    localparam logic [FRM_W-1:0] FRAMES_C = FRM_W'(FRAMES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_VS,
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } state_t;

    // Saturating bin-counter increment.
    function automatic logic [CNT_W-1:0] sat_inc_bin(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Saturating 32-bit total-counter increment.
    function automatic logic [31:0] sat_inc_tot(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    state_t                 state_q;
    logic [BIN_BITS-1:0]    clr_idx_q;
    logic [FRM_W-1:0]       frame_q;
    logic                   drain_q;
    logic                   done_q;
    logic [31:0]            total_q;
    logic                   vs_dly_q;

    logic                   vs_edge;
    logic                   busy;
    logic                   acc_en;
    logic [BIN_BITS-1:0]    bin_idx;

    // Bin-update pipeline: stage p1 holds the bin read last cycle.
    logic                   vld_p1_q;
    logic [BIN_BITS-1:0]    bin_p1_q;
    logic [CNT_W-1:0]       cnt_p1_q;
    logic [CNT_W-1:0]       wr_data_d;
    logic                   fwd;

    logic [CNT_W-1:0]       mem_q [NBINS];

    // AXI read path.
    logic                   ar_hs;
    logic                   ar_v_p1_q;
    logic [BIN_BITS:0]      ar_addr_p1_q;
    logic [31:0]            res_data_d;
    logic [1:0]             res_resp_d;
    logic                   rvalid_q;
    logic [31:0]            rdata_q;
    logic [1:0]             rresp_q;
    logic                   skid_v_q;
    logic [31:0]            skid_data_q;
    logic [1:0]             skid_resp_q;

    logic                   unused_bits;
    assign unused_bits = ^{s_axi_araddr[31:BIN_BITS+3], s_axi_araddr[1:0], pix_i};

    assign vs_edge   = vs_i && !vs_dly_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign acc_en    = (state_q == S_ACCUM) && dv_i && !vs_edge;
    assign bin_idx   = pix_i[PIX_W-1 -: BIN_BITS];
    assign wr_data_d = sat_inc_bin(cnt_p1_q);
    // A write landing this cycle on the bin being read supplies the fresh value.
    assign fwd       = vld_p1_q && (bin_p1_q == bin_idx);

    // Run-control FSM: clear, wait for the first frame, accumulate, drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            clr_idx_q <= '0;
            frame_q   <= '0;
            drain_q   <= 1'b0;
            done_q    <= 1'b0;
            total_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (cpu_trigger) begin
                        state_q   <= S_CLEAR;
                        clr_idx_q <= '0;
                        frame_q   <= '0;
                        done_q    <= 1'b0;
                        total_q   <= '0;
                    end
                end
                S_CLEAR: begin
                    clr_idx_q <= clr_idx_q + BIN_BITS'(1);
                    if (clr_idx_q == '1) begin
                        state_q <= S_WAIT_VS;
                    end
                end
                S_WAIT_VS: begin
                    if (vs_edge) begin
                        state_q <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (vs_edge) begin
                        frame_q <= frame_q + FRM_W'(1);
                        if (frame_q + FRM_W'(1) == FRAMES_C) begin
                            state_q <= S_DRAIN;
                            drain_q <= 1'b0;
                        end
                    end else if (dv_i) begin
                        total_q <= sat_inc_tot(total_q);
                    end
                end
                S_DRAIN: begin
                    // Two cycles let the last in-flight bin write retire.
                    if (drain_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Read stage of the bin increment, with same-bin forwarding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_dly_q <= 1'b0;
            vld_p1_q <= 1'b0;
            bin_p1_q <= '0;
            cnt_p1_q <= '0;
        end else begin
            vs_dly_q <= vs_i;
            vld_p1_q <= acc_en;
            bin_p1_q <= bin_idx;
            cnt_p1_q <= fwd ? wr_data_d : mem_q[bin_idx];
        end
    end

    // Bin memory write port: clear sweep or pipelined increment; never reset.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem_q[clr_idx_q] <= '0;
        end else if (vld_p1_q) begin
            mem_q[bin_p1_q] <= wr_data_d;
        end
    end

    assign ar_hs = s_axi_arvalid && s_axi_arready;

    // Decode of the captured read address into response data and status.
    always_comb begin
        res_data_d = '0;
        res_resp_d = 2'b00;
        if (ar_addr_p1_q[BIN_BITS]) begin
            if (ar_addr_p1_q[BIN_BITS-1:0] == BIN_BITS'(0)) begin
                res_data_d = {30'b0, busy, done_q};
            end else if (ar_addr_p1_q[BIN_BITS-1:0] == BIN_BITS'(1)) begin
                res_data_d = total_q;
            end
        end else if (busy) begin
            res_resp_d = 2'b10;
        end else begin
            res_data_d = 32'(mem_q[ar_addr_p1_q[BIN_BITS-1:0]]);
        end
    end

    // AXI read channel: one address stage, then the response register with a
    // one-entry skid for a read accepted while the previous one was in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ar_v_p1_q    <= 1'b0;
            ar_addr_p1_q <= '0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= 2'b00;
            skid_v_q     <= 1'b0;
            skid_data_q  <= '0;
            skid_resp_q  <= 2'b00;
        end else begin
            ar_v_p1_q    <= ar_hs;
            ar_addr_p1_q <= s_axi_araddr[BIN_BITS+2:2];
            if (!rvalid_q || s_axi_rready) begin
                if (skid_v_q) begin
                    rvalid_q    <= 1'b1;
                    rdata_q     <= skid_data_q;
                    rresp_q     <= skid_resp_q;
                    skid_v_q    <= ar_v_p1_q;
                    skid_data_q <= res_data_d;
                    skid_resp_q <= res_resp_d;
                end else if (ar_v_p1_q) begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= res_data_d;
                    rresp_q  <= res_resp_d;
                end else begin
                    rvalid_q <= 1'b0;
                end
            end else if (ar_v_p1_q) begin
                skid_v_q    <= 1'b1;
                skid_data_q <= res_data_d;
                skid_resp_q <= res_resp_d;
            end
        end
    end

    assign s_axi_arready   = !rvalid_q;
    assign s_axi_rvalid    = rvalid_q;
    assign s_axi_rdata     = rdata_q;
    assign s_axi_rresp     = rresp_q;
    assign cpu_signal_done = done_q;

endmodule

// File: tb/tb_histogram_engine.sv
// tb_histogram_engine: two engines (defaults, and CNT_W=4 / FRAMES=3) driven by
// directed vectors and checked every cycle against a behavioural model.
module tb_histogram_engine;

    localparam int BIN_BITS = 8;
    localparam logic [31:0] REG_BASE = 32'h0000_0400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [1:0][7:0]       pix_w;
    logic [1:0]            dv_w, vs_w, trig_w, arvalid_w, rready_w;
    logic [1:0][31:0]      araddr_w;
    wire  [1:0]            done_w, arready_w, rvalid_w;
    wire  [1:0][31:0]      rdata_w;
    wire  [1:0][1:0]       rresp_w;

    int n_cmp  = 0;
    int n_fail = 0;

    histogram_engine #(.PIX_W(8), .BIN_BITS(8), .CNT_W(24), .FRAMES(1)) u_def (
        .clk(clk), .rst(rst), .pix_i(pix_w[0]), .dv_i(dv_w[0]), .vs_i(vs_w[0]),
        .cpu_trigger(trig_w[0]), .cpu_signal_done(done_w[0]),
        .s_axi_araddr(araddr_w[0]), .s_axi_arvalid(arvalid_w[0]), .s_axi_arready(arready_w[0]),
        .s_axi_rdata(rdata_w[0]), .s_axi_rresp(rresp_w[0]), .s_axi_rvalid(rvalid_w[0]),
        .s_axi_rready(rready_w[0]));

    histogram_engine #(.PIX_W(8), .BIN_BITS(8), .CNT_W(4), .FRAMES(3)) u_alt (
        .clk(clk), .rst(rst), .pix_i(pix_w[1]), .dv_i(dv_w[1]), .vs_i(vs_w[1]),
        .cpu_trigger(trig_w[1]), .cpu_signal_done(done_w[1]),
        .s_axi_araddr(araddr_w[1]), .s_axi_arvalid(arvalid_w[1]), .s_axi_arready(arready_w[1]),
        .s_axi_rdata(rdata_w[1]), .s_axi_rresp(rresp_w[1]), .s_axi_rvalid(rvalid_w[1]),
        .s_axi_rready(rready_w[1]));

    // ---------------- behavioural model ----------------
    int          m_clear  [2];
    bit          m_wait   [2];
    bit          m_acc    [2];
    int          m_frames [2];
    int          m_drain  [2];
    bit          m_done   [2];
    longint      m_total  [2];
    int          m_bins   [2][256];
    bit          m_vsd    [2];
    bit          m_pend   [2];
    logic [31:0] m_paddr  [2];
    bit          m_rv     [2];
    logic [31:0] m_rdata  [2];
    logic [1:0]  m_rresp  [2];

    function automatic int frames_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int cmax_of(input int i);
        return (i == 0) ? 24'hFFFFFF : 15;
    endfunction

    function automatic bit m_busy(input int i);
        return (m_clear[i] > 0) || m_wait[i] || m_acc[i] || (m_drain[i] > 0);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_clear[i] = 0; m_wait[i] = 0; m_acc[i] = 0; m_frames[i] = 0;
                m_drain[i] = 0; m_done[i] = 0; m_total[i] = 0; m_vsd[i] = 0;
                m_pend[i] = 0; m_rv[i] = 0; m_rdata[i] = 0; m_rresp[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                // read channel: retire, then produce the result of last cycle's request
                if (m_rv[i] && rready_w[i]) m_rv[i] = 0;
                if (m_pend[i]) begin
                    m_pend[i] = 0;
                    m_rv[i]   = 1;
                    m_rresp[i] = 2'b00;
                    m_rdata[i] = 32'd0;
                    if (m_paddr[i][BIN_BITS+2]) begin
                        if (m_paddr[i][BIN_BITS+1:2] == 0)
                            m_rdata[i] = {30'd0, m_busy(i), m_done[i]};
                        else if (m_paddr[i][BIN_BITS+1:2] == 1)
                            m_rdata[i] = m_total[i][31:0];
                    end else if (m_busy(i)) begin
                        m_rresp[i] = 2'b10;
                    end else begin
                        m_rdata[i] = 32'(m_bins[i][m_paddr[i][BIN_BITS+1:2]]);
                    end
                end
                if (arvalid_w[i]) begin
                    m_pend[i]  = 1;
                    m_paddr[i] = araddr_w[i];
                end
                // run control
                if (trig_w[i] && !m_busy(i)) begin
                    m_clear[i] = 256; m_done[i] = 0; m_total[i] = 0; m_frames[i] = 0;
                    for (int b = 0; b < 256; b++) m_bins[i][b] = 0;
                end else if (m_clear[i] > 0) begin
                    m_clear[i]--;
                    if (m_clear[i] == 0) m_wait[i] = 1;
                end else if (m_wait[i]) begin
                    if (vs_w[i] && !m_vsd[i]) begin m_wait[i] = 0; m_acc[i] = 1; end
                end else if (m_acc[i]) begin
                    if (vs_w[i] && !m_vsd[i]) begin
                        m_frames[i]++;
                        if (m_frames[i] == frames_of(i)) begin m_acc[i] = 0; m_drain[i] = 2; end
                    end else if (dv_w[i]) begin
                        if (m_bins[i][pix_w[i]] < cmax_of(i)) m_bins[i][pix_w[i]]++;
                        if (m_total[i] < 64'hFFFF_FFFF) m_total[i]++;
                    end
                end else if (m_drain[i] > 0) begin
                    m_drain[i]--;
                    if (m_drain[i] == 0) m_done[i] = 1;
                end
                m_vsd[i] = vs_w[i];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d done", i), 32'(done_w[i]), 32'(m_done[i]));
            chk($sformatf("u%0d rvalid", i), 32'(rvalid_w[i]), 32'(m_rv[i]));
            chk($sformatf("u%0d arready", i), 32'(arready_w[i]), 32'(!m_rv[i]));
            if (m_rv[i]) begin
                chk($sformatf("u%0d rdata", i), rdata_w[i], m_rdata[i]);
                chk($sformatf("u%0d rresp", i), 32'(rresp_w[i]), 32'(m_rresp[i]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int i, input int n, input bit d, input bit v, input logic [7:0] p);
        repeat (n) begin
            @(posedge clk); #1;
            dv_w[i] = d; vs_w[i] = v; pix_w[i] = p;
        end
    endtask

    task automatic vs_pulse(input int i, input bit d, input logic [7:0] p);
        drive(i, 1, d, 1'b1, p);
        drive(i, 1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic trigger(input int i);
        @(posedge clk); #1 trig_w[i] = 1'b1;
        @(posedge clk); #1 trig_w[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input string nm);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_w[i]) break;
        end
        chk(nm, 32'(done_w[i]), 32'd1);
    endtask

    task automatic axi_read(input int i, input logic [31:0] addr,
                            output logic [31:0] data, output logic [1:0] resp);
        bit got;
        got = 0; data = '0; resp = '0;
        @(posedge clk); #1 araddr_w[i] = addr; arvalid_w[i] = 1'b1;
        @(posedge clk); #1 arvalid_w[i] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rvalid_w[i]) begin got = 1; data = rdata_w[i]; resp = rresp_w[i]; break; end
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL axi_timeout u%0d addr %0h: actual no rvalid required rvalid", i, addr);
        end
        @(posedge clk); #1;
    endtask

    task automatic rd_chk(input int i, input logic [31:0] addr, input logic [31:0] exp_d,
                          input logic [1:0] exp_r, input string nm);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(i, addr, d, r);
        chk({nm, "_data"}, d, exp_d);
        chk({nm, "_resp"}, 32'(r), 32'(exp_r));
    endtask

    task automatic chk_reset_vals(input int i, input string nm);
        chk({nm, "_done"},    32'(done_w[i]),    32'd0);
        chk({nm, "_arready"}, 32'(arready_w[i]), 32'd1);
        chk({nm, "_rvalid"},  32'(rvalid_w[i]),  32'd0);
        chk({nm, "_rdata"},   rdata_w[i],        32'd0);
        chk({nm, "_rresp"},   32'(rresp_w[i]),   32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        rst = 1'b0;
        pix_w = '0; dv_w = '0; vs_w = '0; trig_w = '0;
        araddr_w = '0; arvalid_w = '0; rready_w = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals(0, "rst_u0");
        chk_reset_vals(1, "rst_u1");
        rst = 1'b1;

        // defaults: 1000 pixels of 0x37, final vs edge carries a pixel
        trigger(0);
        drive(0, 260, 1'b0, 1'b0, 8'h00);
        vs_pulse(0, 1'b0, 8'h00);
        drive(0, 1000, 1'b1, 1'b0, 8'h37);
        vs_pulse(0, 1'b1, 8'h37);
        wait_done(0, "def_done");
        rd_chk(0, 32'h37 * 4, 32'd1000, 2'b00, "def_bin37");
        rd_chk(0, 32'h00 * 4, 32'd0, 2'b00, "def_bin00");
        rd_chk(0, 32'hFF * 4, 32'd0, 2'b00, "def_binFF");
        rd_chk(0, REG_BASE + 0, 32'd1, 2'b00, "def_status");
        rd_chk(0, REG_BASE + 4, 32'd1000, 2'b00, "def_total");
        rd_chk(0, REG_BASE + 8, 32'd0, 2'b00, "def_word2");
        rd_chk(0, 32'hFFFF_F404, 32'd1000, 2'b00, "def_alias");

        // response held while rready is low
        rready_w[0] = 1'b0;
        axi_read(0, 32'h37 * 4, d, r);
        chk("stall_first_data", d, 32'd1000);
        repeat (5) begin
            @(negedge clk);
            chk("stall_rvalid", 32'(rvalid_w[0]), 32'd1);
            chk("stall_rdata", rdata_w[0], 32'd1000);
            chk("stall_arready", 32'(arready_w[0]), 32'd0);
        end
        @(posedge clk); #1 rready_w[0] = 1'b1;
        drive(0, 3, 1'b0, 1'b0, 8'h00);

        // forwarding: A,A,B,A,A back to back
        trigger(0);
        rd_chk(0, 32'h37 * 4, 32'd0, 2'b10, "clear_slverr");
        drive(0, 260, 1'b0, 1'b0, 8'h00);
        vs_pulse(0, 1'b0, 8'h00);
        drive(0, 2, 1'b1, 1'b0, 8'h10);
        drive(0, 1, 1'b1, 1'b0, 8'h20);
        drive(0, 2, 1'b1, 1'b0, 8'h10);
        drive(0, 3, 1'b0, 1'b0, 8'h00);
        vs_pulse(0, 1'b0, 8'h00);
        wait_done(0, "fwd_done");
        rd_chk(0, 32'h10 * 4, 32'd4, 2'b00, "fwd_binA");
        rd_chk(0, 32'h20 * 4, 32'd1, 2'b00, "fwd_binB");
        rd_chk(0, 32'h37 * 4, 32'd0, 2'b00, "fwd_bin37_cleared");
        rd_chk(0, REG_BASE + 4, 32'd5, 2'b00, "fwd_total");

        // FRAMES=3: 10 pixels per frame, read during ACCUM
        trigger(1);
        drive(1, 260, 1'b0, 1'b0, 8'h00);
        vs_pulse(1, 1'b0, 8'h00);
        drive(1, 10, 1'b1, 1'b0, 8'h01);
        drive(1, 1, 1'b0, 1'b0, 8'h00);
        rd_chk(1, 32'h01 * 4, 32'd0, 2'b10, "accum_slverr");
        vs_pulse(1, 1'b0, 8'h00);
        drive(1, 10, 1'b1, 1'b0, 8'h02);
        vs_pulse(1, 1'b0, 8'h00);
        drive(1, 10, 1'b1, 1'b0, 8'h03);
        drive(1, 3, 1'b0, 1'b0, 8'h00);
        chk("frm_not_done_before_4th", 32'(done_w[1]), 32'd0);
        vs_pulse(1, 1'b0, 8'h00);
        wait_done(1, "frm_done");
        rd_chk(1, REG_BASE + 4, 32'd30, 2'b00, "frm_total");
        rd_chk(1, 32'h02 * 4, 32'd10, 2'b00, "frm_bin2");

        // saturation at CNT_W=4
        trigger(1);
        drive(1, 260, 1'b0, 1'b0, 8'h00);
        vs_pulse(1, 1'b0, 8'h00);
        drive(1, 20, 1'b1, 1'b0, 8'hAA);
        drive(1, 1, 1'b0, 1'b0, 8'h00);
        vs_pulse(1, 1'b0, 8'h00);
        vs_pulse(1, 1'b0, 8'h00);
        vs_pulse(1, 1'b0, 8'h00);
        wait_done(1, "sat_done");
        rd_chk(1, 32'hAA * 4, 32'd15, 2'b00, "sat_bin");
        rd_chk(1, REG_BASE + 4, 32'd20, 2'b00, "sat_total");
        rd_chk(1, 32'h01 * 4, 32'd0, 2'b00, "sat_bin1_cleared");

        // reset in the middle of an accumulation with a read in flight
        trigger(0);
        drive(0, 260, 1'b0, 1'b0, 8'h00);
        vs_pulse(0, 1'b0, 8'h00);
        drive(0, 50, 1'b1, 1'b0, 8'h11);
        drive(0, 1, 1'b0, 1'b0, 8'h00);
        araddr_w[0] = REG_BASE; arvalid_w[0] = 1'b1;
        @(posedge clk); #1 arvalid_w[0] = 1'b0;
        #2 rst = 1'b0;
        #1 chk_reset_vals(0, "midrst");
        @(posedge clk); #1 rst = 1'b1;
        drive(0, 4, 1'b0, 1'b0, 8'h00);
        rd_chk(0, REG_BASE + 0, 32'd0, 2'b00, "midrst_status");
        trigger(0);
        drive(0, 260, 1'b0, 1'b0, 8'h00);
        vs_pulse(0, 1'b0, 8'h00);
        drive(0, 300, 1'b1, 1'b0, 8'h80);
        vs_pulse(0, 1'b0, 8'h00);
        wait_done(0, "rerun_done");
        rd_chk(0, 32'h80 * 4, 32'd300, 2'b00, "rerun_bin80");
        rd_chk(0, 32'h11 * 4, 32'd0, 2'b00, "rerun_bin11");
        rd_chk(0, REG_BASE + 4, 32'd300, 2'b00, "rerun_total");

        drive(0, 4, 1'b0, 1'b0, 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
